id_ex_reg: RTL and testbench

Pipeline register between the instruction-decode and execute stages of the 5-stage MIPS core. Captures the decoded operation, forwarded operands, write-back control, PC, and exception set from ID each cycle. Implements the stall/flush contract from the pipeline controller: hold, insert a NOP bubble, or clear. Returns the delay-slot flag to ID and counts inserted bubbles for performance monitoring.

---
 rtl/id_ex_reg_if.sv | 73 +++++++
 rtl/id_ex_reg.sv | 94 +++++++++
 tb/tb_id_ex_reg.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_reg_if.sv
// Shared pipeline types and the ID->EX bundle between the decode stage,
// the pipeline controller and the ID/EX register.
package mips_pkg;
  typedef logic [7:0]  Oper_t;
  typedef logic [31:0] Word_t;
  typedef logic        Bit_t;
  typedef logic [4:0]  Reg_addr_t;
  typedef logic [31:0] Inst_addr_t;
  typedef logic [7:0]  Excp_set_t;

  localparam Oper_t      OP_NOP        = 8'h00;
  localparam Oper_t      OP_ADDU       = 8'h01;
  localparam Oper_t      OP_LW         = 8'h20;
  localparam Oper_t      OP_BEQ        = 8'h30;
  localparam Word_t      ZERO_WORD     = 32'h0000_0000;
  localparam Bit_t       ENABLE        = 1'b1;
  localparam Bit_t       DISABLE       = 1'b0;
  localparam Reg_addr_t  REG_ZERO      = 5'd0;
  localparam Inst_addr_t PC_RESET_ADDR = 32'hBFC0_0000;
  localparam Excp_set_t  NO_EXCP       = 8'h00;
endpackage

interface id_ex_if
  import mips_pkg::*;
#(
  parameter int CNT_WIDTH = 32
);
  logic                 stall_id;
  logic                 stall_ex;
  logic                 flush;
  Oper_t                id_oper;
  Word_t                id_reg1;
  Word_t                id_reg2;
  Bit_t                 id_wreg_write;
  Reg_addr_t            id_wreg_addr;
  Inst_addr_t           id_pc;
  Inst_addr_t           id_inst_addr_v;
  Bit_t                 id_is_in_delayslot;
  Bit_t                 id_next_is_in_delayslot;
  Excp_set_t            id_exception_type;
  Oper_t                ex_oper;
  Word_t                ex_reg1;
  Word_t                ex_reg2;
  Bit_t                 ex_wreg_write;
  Reg_addr_t            ex_wreg_addr;
  Inst_addr_t           ex_pc;
  Inst_addr_t           ex_inst_addr_v;
  Bit_t                 ex_is_in_delayslot;
  Excp_set_t            ex_exception_type;
  Bit_t                 is_in_delayslot_o;
  logic                 ex_valid;
  logic [CNT_WIDTH-1:0] bubble_cnt;

  modport master (
    output stall_id, stall_ex, flush,
    output id_oper, id_reg1, id_reg2, id_wreg_write, id_wreg_addr, id_pc,
    output id_inst_addr_v, id_is_in_delayslot, id_next_is_in_delayslot,
    output id_exception_type,
    input  ex_oper, ex_reg1, ex_reg2, ex_wreg_write, ex_wreg_addr, ex_pc,
    input  ex_inst_addr_v, ex_is_in_delayslot, ex_exception_type,
    input  is_in_delayslot_o, ex_valid, bubble_cnt
  );

  modport slave (
    input  stall_id, stall_ex, flush,
    input  id_oper, id_reg1, id_reg2, id_wreg_write, id_wreg_addr, id_pc,
    input  id_inst_addr_v, id_is_in_delayslot, id_next_is_in_delayslot,
    input  id_exception_type,
    output ex_oper, ex_reg1, ex_reg2, ex_wreg_write, ex_wreg_addr, ex_pc,
    output ex_inst_addr_v, ex_is_in_delayslot, ex_exception_type,
    output is_in_delayslot_o, ex_valid, bubble_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: hold on EX stall, NOP bubble on ID-only stall,
// clear on flush; feeds the delay-slot flag back to ID and counts bubbles.
module id_ex_reg
  import mips_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input logic    clk,
  input logic    rst,
  id_ex_if.slave bus
);

  Oper_t                oper_q;
  Word_t                reg1_q;
  Word_t                reg2_q;
  Bit_t                 wreg_write_q;
  Reg_addr_t            wreg_addr_q;
  Inst_addr_t           pc_q;
  Inst_addr_t           inst_addr_v_q;
  Bit_t                 is_in_ds_q;
  Excp_set_t            excp_q;
  Bit_t                 next_ds_q;
  logic                 valid_q;
  logic [CNT_WIDTH-1:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      oper_q        <= OP_NOP;
      reg1_q        <= ZERO_WORD;
      reg2_q        <= ZERO_WORD;
      wreg_write_q  <= DISABLE;
      wreg_addr_q   <= REG_ZERO;
      pc_q          <= PC_RESET_ADDR;
      inst_addr_v_q <= PC_RESET_ADDR;
      is_in_ds_q    <= DISABLE;
      excp_q        <= NO_EXCP;
      next_ds_q     <= DISABLE;
      valid_q       <= 1'b0;
      bubble_cnt_q  <= '0;
    end else if (bus.flush) begin
      oper_q        <= OP_NOP;
      reg1_q        <= ZERO_WORD;
      reg2_q        <= ZERO_WORD;
      wreg_write_q  <= DISABLE;
      wreg_addr_q   <= REG_ZERO;
      pc_q          <= PC_RESET_ADDR;
      inst_addr_v_q <= PC_RESET_ADDR;
      is_in_ds_q    <= DISABLE;
      excp_q        <= NO_EXCP;
      next_ds_q     <= DISABLE;
      valid_q       <= 1'b0;
    end else if (bus.stall_ex) begin
      // EX frozen: everything holds, including the counter
    end else if (bus.stall_id) begin
      // Bubble keeps PC and the pending delay-slot flag so a branch's
      // delay slot is still recognised after any number of bubbles.
      oper_q        <= OP_NOP;
      reg1_q        <= ZERO_WORD;
      reg2_q        <= ZERO_WORD;
      wreg_write_q  <= DISABLE;
      wreg_addr_q   <= REG_ZERO;
      is_in_ds_q    <= DISABLE;
      excp_q        <= NO_EXCP;
      valid_q       <= 1'b0;
      bubble_cnt_q  <= bubble_cnt_q + 1'b1;
    end else begin
      oper_q        <= bus.id_oper;
      reg1_q        <= bus.id_reg1;
      reg2_q        <= bus.id_reg2;
      wreg_write_q  <= bus.id_wreg_write;
      wreg_addr_q   <= bus.id_wreg_addr;
      pc_q          <= bus.id_pc;
      inst_addr_v_q <= bus.id_inst_addr_v;
      is_in_ds_q    <= bus.id_is_in_delayslot;
      excp_q        <= bus.id_exception_type;
      next_ds_q     <= bus.id_next_is_in_delayslot;
      valid_q       <= 1'b1;
    end
  end

  assign bus.ex_oper            = oper_q;
  assign bus.ex_reg1            = reg1_q;
  assign bus.ex_reg2            = reg2_q;
  assign bus.ex_wreg_write      = wreg_write_q;
  assign bus.ex_wreg_addr       = wreg_addr_q;
  assign bus.ex_pc              = pc_q;
  assign bus.ex_inst_addr_v     = inst_addr_v_q;
  assign bus.ex_is_in_delayslot = is_in_ds_q;
  assign bus.ex_exception_type  = excp_q;
  assign bus.is_in_delayslot_o  = next_ds_q;
  assign bus.ex_valid           = valid_q;
  assign bus.bubble_cnt         = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: a behavioural model predicts the visible
// register contents after each edge; a monitor compares them after the edge.
module tb_id_ex_reg;
  import mips_pkg::*;

  localparam int CW = 4;

  typedef struct packed {
    logic [7:0]    oper;
    logic [31:0]   r1;
    logic [31:0]   r2;
    logic          ww;
    logic [4:0]    wa;
    logic [31:0]   pc;
    logic [31:0]   pcv;
    logic          ids;
    logic [7:0]    exc;
    logic          dso;
    logic          valid;
    logic [CW-1:0] cnt;
  } view_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_if #(.CNT_WIDTH(CW)) bus ();

  id_ex_reg #(.CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  view_t exp_q[$];
  view_t model;
  int    checks   = 0;
  int    failures = 0;
  int    bubbles  = 0;
  bit    done     = 1'b0;

  function automatic view_t reset_view(input int count);
    view_t v;
    v.oper  = OP_NOP;        v.r1  = 32'h0;  v.r2  = 32'h0;
    v.ww    = 1'b0;          v.wa  = 5'd0;
    v.pc    = 32'hBFC0_0000; v.pcv = 32'hBFC0_0000;
    v.ids   = 1'b0;          v.exc = 8'h00;  v.dso = 1'b0;
    v.valid = 1'b0;
    v.cnt   = CW'(count % (1 << CW));
    return v;
  endfunction

  // Expected view after the coming edge, from the current inputs.
  task automatic cyc();
    view_t n;
    n = model;
    if (rst) begin
      bubbles = 0;
      n = reset_view(0);
    end else if (bus.flush) begin
      n = reset_view(bubbles);
    end else if (bus.stall_ex) begin
      n = model;
    end else if (bus.stall_id) begin
      bubbles = bubbles + 1;
      n = reset_view(bubbles);
      n.pc  = model.pc;
      n.pcv = model.pcv;
      n.dso = model.dso;
    end else begin
      n.oper = bus.id_oper;        n.r1  = bus.id_reg1;   n.r2 = bus.id_reg2;
      n.ww   = bus.id_wreg_write;  n.wa  = bus.id_wreg_addr;
      n.pc   = bus.id_pc;          n.pcv = bus.id_inst_addr_v;
      n.ids  = bus.id_is_in_delayslot;
      n.exc  = bus.id_exception_type;
      n.dso  = bus.id_next_is_in_delayslot;
      n.valid = 1'b1;
    end
    model = n;
    exp_q.push_back(n);
    @(negedge clk);
  endtask

  task automatic rand_id();
    bus.id_oper                 = 8'($urandom_range(1, 255));
    bus.id_reg1                 = $urandom;
    bus.id_reg2                 = $urandom;
    bus.id_wreg_write           = 1'($urandom);
    bus.id_wreg_addr            = 5'($urandom);
    bus.id_pc                   = $urandom;
    bus.id_inst_addr_v          = $urandom;
    bus.id_is_in_delayslot      = 1'($urandom);
    bus.id_next_is_in_delayslot = 1'($urandom);
    bus.id_exception_type       = 8'($urandom);
  endtask

  task automatic ctl(input logic r, input logic f, input logic sx, input logic si);
    rst          = r;
    bus.flush    = f;
    bus.stall_ex = sx;
    bus.stall_id = si;
  endtask

  // Monitor: every edge that has a prediction gets compared.
  initial begin
    view_t act, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act.oper = bus.ex_oper;         act.r1  = bus.ex_reg1;  act.r2 = bus.ex_reg2;
        act.ww   = bus.ex_wreg_write;   act.wa  = bus.ex_wreg_addr;
        act.pc   = bus.ex_pc;           act.pcv = bus.ex_inst_addr_v;
        act.ids  = bus.ex_is_in_delayslot;
        act.exc  = bus.ex_exception_type;
        act.dso  = bus.is_in_delayslot_o;
        act.valid = bus.ex_valid;
        act.cnt  = bus.bubble_cnt;
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL ex_view t=%0t got oper=%h r1=%h r2=%h ww=%b wa=%0d pc=%h pcv=%h ids=%b exc=%h dso=%b v=%b cnt=%0d | want oper=%h r1=%h r2=%h ww=%b wa=%0d pc=%h pcv=%h ids=%b exc=%h dso=%b v=%b cnt=%0d",
                   $time, act.oper, act.r1, act.r2, act.ww, act.wa, act.pc, act.pcv, act.ids, act.exc, act.dso, act.valid, act.cnt,
                   e.oper, e.r1, e.r2, e.ww, e.wa, e.pc, e.pcv, e.ids, e.exc, e.dso, e.valid, e.cnt);
        end
      end
    end
  end

  initial begin
    model = reset_view(0);
    ctl(1'b1, 1'b0, 1'b0, 1'b0);
    rand_id();
    @(negedge clk);

    // reset with nonzero ID inputs
    cyc(); rand_id(); cyc();

    // plain advance
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    rand_id();
    bus.id_oper = OP_ADDU; bus.id_reg1 = 32'h5; bus.id_reg2 = 32'h7;
    bus.id_wreg_write = 1'b1; bus.id_wreg_addr = 5'd3; bus.id_pc = 32'hBFC0_0010;
    cyc();

    // load-use: LW enters, one bubble, then next instruction
    rand_id(); bus.id_oper = OP_LW; bus.id_wreg_write = 1'b1; cyc();
    ctl(1'b0, 1'b0, 1'b0, 1'b1); rand_id(); cyc();
    ctl(1'b0, 1'b0, 1'b0, 1'b0); rand_id(); cyc();

    // branch, three bubbles, then its delay-slot instruction
    rand_id(); bus.id_oper = OP_BEQ; bus.id_next_is_in_delayslot = 1'b1; cyc();
    ctl(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) begin rand_id(); cyc(); end
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    rand_id(); bus.id_is_in_delayslot = 1'b1; bus.id_next_is_in_delayslot = 1'b0; cyc();

    // hold twice (stall_id ignored), then flush overrides stall_ex
    rand_id(); bus.id_next_is_in_delayslot = 1'b1; cyc();
    ctl(1'b0, 1'b0, 1'b1, 1'b0); rand_id(); cyc();
    ctl(1'b0, 1'b0, 1'b1, 1'b1); rand_id(); cyc();
    ctl(1'b0, 1'b1, 1'b1, 1'b0); rand_id(); cyc();
    ctl(1'b0, 1'b1, 1'b0, 1'b1); rand_id(); cyc();

    // counter wrap: enough bubbles to pass all-ones
    ctl(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (20) begin rand_id(); cyc(); end

    // reset in the middle of a stall
    ctl(1'b1, 1'b0, 1'b1, 1'b1); rand_id(); cyc();
    ctl(1'b0, 1'b0, 1'b0, 1'b0); rand_id(); cyc();

    // random mix of all controls
    for (int i = 0; i < 3000; i++) begin
      ctl(($urandom_range(0, 63) == 0), ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
      rand_id();
      cyc();
    end

    ctl(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      begin
        #500000;
        failures++;
        $display("FAIL timeout reached want finish");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
